// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
// Passive responder on the character-LCD write bus. It taps the same lcd_*
// nets as the LCD driver (never drives them), decodes HD44780-style command
// and data writes on the falling edge of E, and keeps a 2x16 shadow of the
// display contents that other logic can read.
//
// Ports
//   clk, rst        system clock, asynchronous active-low reset
//   lcd_RS/RW/E/DB  LCD write bus (RS: 0 cmd / 1 data, RW: 1 = read request)
//   lcd_ON          panel power; bus events are ignored while it is low
//   rd_addr/rd_data combinational read of the shadow buffer (0-15 line 0,
//                   16-31 line 1)
//   cur_addr        current write index
//   display_on      D bit of the last display-control command
//   busy            high while a clear sweep is running
//   cmd_strobe      one-cycle pulse per accepted command
//   frame_done      one-cycle pulse when a data write lands on index 31 with
//                   increment mode set
//   err_flags       sticky: [0] short E, [1] read attempt, [2] bad DDRAM
//                   address, [3] write while busy
//
// Bus handshake: there is no back-pressure. A write event is the cycle where
// the registered E is high and the live E is low; it is qualified in the order
// power, E width, RW, busy, and its effect is registered on that same clock
// edge, so results and pulses are visible the cycle after detection.
module lcd_bus_responder #(
  parameter int          MIN_E_HIGH = 4,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_RS,
  input  logic       lcd_RW,
  input  logic       lcd_E,
  input  logic [7:0] lcd_DB,
  input  logic       lcd_ON,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cur_addr,
  output logic       display_on,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       frame_done,
  output logic [3:0] err_flags
);

  localparam int             CW    = $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0]  E_SAT = CW'(MIN_E_HIGH);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t      state, state_next;
  logic        e_d, rs_d, rw_d;
  logic [7:0]  db_d;
  logic [CW-1:0] e_cnt;
  logic [7:0]  buffer [32];
  logic [4:0]  sweep;
  logic        inc_mode;

  logic fall, ev_valid, err_timing, err_read, err_over;
  logic accept, cmd_acc, data_acc, is_clear, ddram_ok;

  // Input sampling stage plus a saturating count of cycles E has been high.
  // The count is still valid in the detection cycle because it only clears
  // on the edge that samples E low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_d   <= 1'b0;
      rs_d  <= 1'b0;
      rw_d  <= 1'b0;
      db_d  <= 8'h00;
      e_cnt <= '0;
    end else begin
      e_d  <= lcd_E;
      rs_d <= lcd_RS;
      rw_d <= lcd_RW;
      db_d <= lcd_DB;
      if (!lcd_E)
        e_cnt <= '0;
      else if (e_cnt != E_SAT)
        e_cnt <= e_cnt + 1'b1;
    end
  end

  // Event qualification and next-state logic.
  always_comb begin
    fall       = e_d & ~lcd_E;
    ev_valid   = fall & lcd_ON;
    err_timing = ev_valid & (e_cnt < E_SAT);
    err_read   = ev_valid & ~err_timing & rw_d;
    err_over   = ev_valid & ~err_timing & ~rw_d & busy;
    accept     = ev_valid & ~err_timing & ~rw_d & ~busy;
    cmd_acc    = accept & ~rs_d;
    data_acc   = accept & rs_d;
    is_clear   = cmd_acc & (db_d == 8'h01);
    // DDRAM addresses 0x00-0x0F map to line 0, 0x40-0x4F to line 1.
    ddram_ok   = (db_d[6:4] == 3'b000) || (db_d[6:4] == 3'b100);

    state_next = state;
    case (state)
      IDLE:  if (is_clear) state_next = CLEAR;
      CLEAR: if (sweep == 5'd31) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  assign busy    = (state == CLEAR);
  assign rd_data = buffer[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) buffer[i] <= BLANK_CHAR;
      cur_addr   <= 5'd0;
      inc_mode   <= 1'b1;
      display_on <= 1'b0;
      cmd_strobe <= 1'b0;
      frame_done <= 1'b0;
      err_flags  <= 4'h0;
      sweep      <= 5'd0;
    end else begin
      cmd_strobe <= cmd_acc;
      frame_done <= data_acc & inc_mode & (cur_addr == 5'd31);

      if (err_timing) err_flags[0] <= 1'b1;
      if (err_read)   err_flags[1] <= 1'b1;
      if (err_over)   err_flags[3] <= 1'b1;

      if (busy) begin
        buffer[sweep] <= BLANK_CHAR;
        sweep         <= sweep + 1'b1;
        if (sweep == 5'd31) begin
          cur_addr <= 5'd0;
          inc_mode <= 1'b1;
        end
      end

      if (data_acc) begin
        buffer[cur_addr] <= db_d;
        // 5-bit arithmetic gives the 31->0 and 0->31 wrap for free.
        cur_addr <= inc_mode ? cur_addr + 1'b1 : cur_addr - 1'b1;
      end

      if (cmd_acc) begin
        if (db_d == 8'h01)
          sweep <= 5'd0;
        else if (db_d[7:1] == 7'b0000001)
          cur_addr <= 5'd0;
        else if (db_d[7:2] == 6'b000001)
          inc_mode <= db_d[1];
        else if (db_d[7:3] == 5'b00001)
          display_on <= db_d[2];
        else if (db_d[7]) begin
          if (ddram_ok) cur_addr <= {db_d[6], db_d[3:0]};
          else          err_flags[2] <= 1'b1;
        end
        // 0x00 and 0x10-0x7F are accepted without any state change.
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder. Inputs change on the falling clock
// edge and outputs are sampled on the falling edge, away from the active edge.
module tb_lcd_bus_responder;

  logic       clk;
  logic       rst;
  logic       lcd_RS, lcd_RW, lcd_E, lcd_ON;
  logic [7:0] lcd_DB;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cur_addr;
  logic       display_on, busy, cmd_strobe, frame_done;
  logic [3:0] err_flags;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int busy_cnt = 0;

  lcd_bus_responder #(.MIN_E_HIGH(4), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst),
    .lcd_RS(lcd_RS), .lcd_RW(lcd_RW), .lcd_E(lcd_E), .lcd_DB(lcd_DB),
    .lcd_ON(lcd_ON), .rd_addr(rd_addr), .rd_data(rd_data),
    .cur_addr(cur_addr), .display_on(display_on), .busy(busy),
    .cmd_strobe(cmd_strobe), .frame_done(frame_done), .err_flags(err_flags)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus write: E high for 'width' sampled cycles, then low. Returns at
  // the first falling clock edge where the write's effect is visible.
  task automatic bus_write(input logic rs, input logic rw, input logic [7:0] db,
                           input int width);
    @(negedge clk);
    lcd_RS = rs; lcd_RW = rw; lcd_DB = db; lcd_E = 1'b1;
    repeat (width) @(negedge clk);
    lcd_E = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  logic [7:0] d;

  initial begin
    rst = 1'b0; lcd_RS = 0; lcd_RW = 0; lcd_E = 0; lcd_DB = 0; lcd_ON = 0;
    rd_addr = 0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_rd0", rd_data, 8'h20);
    check("rst_cur", cur_addr, 0);
    check("rst_disp", display_on, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", cmd_strobe, 0);
    check("rst_fd", frame_done, 0);
    check("rst_err", err_flags, 0);
    rst = 1'b1;
    lcd_ON = 1'b1;

    // Two data writes
    bus_write(1, 0, 8'h41, 6);
    bus_write(1, 0, 8'h42, 6);
    read_byte(0, d); check("wr_b0", d, 8'h41);
    read_byte(1, d); check("wr_b1", d, 8'h42);
    check("wr_cur", cur_addr, 2);
    check("wr_err", err_flags, 0);

    // DDRAM addressing
    bus_write(0, 0, 8'hC5, 6);
    check("c5_strobe", cmd_strobe, 1);
    check("c5_cur", cur_addr, 21);
    @(negedge clk);
    check("strobe_one_cycle", cmd_strobe, 0);
    bus_write(1, 0, 8'h5A, 6);
    check("5a_cur", cur_addr, 22);
    read_byte(21, d); check("5a_rd", d, 8'h5A);
    bus_write(0, 0, 8'h90, 6);
    check("bad_strobe", cmd_strobe, 1);
    check("bad_err", err_flags, 4'b0100);
    check("bad_cur", cur_addr, 22);

    // Full frame of 32 data writes from address 0
    bus_write(0, 0, 8'h80, 6);
    check("home_cur", cur_addr, 0);
    fd_cnt = 0;
    for (int i = 0; i < 31; i++) bus_write(1, 0, 8'h60 + 8'(i), 5);
    check("fd_before_last", fd_cnt, 0);
    bus_write(1, 0, 8'h7F, 5);
    check("fd_last_pulse", frame_done, 1);
    @(negedge clk);
    check("fd_count", fd_cnt, 1);
    check("frame_cur", cur_addr, 0);
    read_byte(0, d);  check("frame_b0", d, 8'h60);
    read_byte(31, d); check("frame_b31", d, 8'h7F);

    // Clear with an overrun write during the sweep (E exactly MIN_E_HIGH)
    busy_cnt = 0;
    bus_write(0, 0, 8'h01, 4);
    check("clr_busy", busy, 1);
    repeat (3) @(negedge clk);
    bus_write(1, 0, 8'h33, 6);
    repeat (40) @(negedge clk);
    check("clr_busy_cycles", busy_cnt, 32);
    check("clr_busy_done", busy, 0);
    check("clr_err", err_flags, 4'b1100);
    check("clr_cur", cur_addr, 0);
    for (int i = 0; i < 32; i++) begin
      read_byte(5'(i), d);
      check($sformatf("clr_b%0d", i), d, 8'h20);
    end

    // Power off: ignored, no flags
    lcd_ON = 1'b0;
    bus_write(1, 0, 8'h66, 6);
    lcd_ON = 1'b1;
    check("off_cur", cur_addr, 0);
    check("off_err", err_flags, 4'b1100);
    read_byte(0, d); check("off_b0", d, 8'h20);

    // Short E pulse and read attempt
    bus_write(1, 0, 8'h55, 2);
    check("short_err", err_flags, 4'b1101);
    read_byte(0, d); check("short_b0", d, 8'h20);
    check("short_cur", cur_addr, 0);
    bus_write(1, 1, 8'h55, 6);
    check("rw_err", err_flags, 4'b1111);
    check("rw_cur", cur_addr, 0);

    // Decrement mode and display control
    bus_write(0, 0, 8'h04, 6);
    bus_write(1, 0, 8'h77, 6);
    read_byte(0, d); check("dec_b0", d, 8'h77);
    check("dec_cur", cur_addr, 31);
    check("dec_no_fd", frame_done, 0);
    bus_write(0, 0, 8'h0C, 6);
    check("disp_on", display_on, 1);
    bus_write(1, 0, 8'h78, 6);
    check("dec_wrap_cur", cur_addr, 30);
    read_byte(31, d); check("dec_b31", d, 8'h78);

    // Reset in the middle of a clear sweep
    bus_write(0, 0, 8'h01, 6);
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    read_byte(31, d); check("mid_partial_b31", d, 8'h78);
    rst = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_err", err_flags, 0);
    check("mr_cur", cur_addr, 0);
    check("mr_disp", display_on, 0);
    check("mr_strobe", cmd_strobe, 0);
    check("mr_fd", frame_done, 0);
    read_byte(31, d); check("mr_b31", d, 8'h20);
    @(negedge clk);
    rst = 1'b1;
    // Increment mode restored by reset
    bus_write(1, 0, 8'h11, 6);
    check("post_cur", cur_addr, 1);
    read_byte(0, d); check("post_b0", d, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
